// File: rtl/shift_reg_32b_ctrl.sv
// Command sequencer driving sel/din of a WIDTH x DEPTH bidirectional shift register.
// Optional abort input / rsp_abort output enabled by defining SHREG_CTRL_ABORT_EN.
module shift_reg_32b_ctrl #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1024,
    parameter int CW    = 11
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             VDD,
    input  logic             GND,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [CW-1:0]    cmd_count,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [WIDTH-1:0] head_q,
    input  logic [WIDTH-1:0] tail_q,
    output logic [1:0]       sr_sel,
    output logic [WIDTH-1:0] sr_din,
`ifdef SHREG_CTRL_ABORT_EN
    input  logic             abort,
    output logic             rsp_abort,
`endif
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        RESP
    } state_e;

    typedef enum logic [2:0] {
        OP_SHR   = 3'b000,
        OP_SHL   = 3'b001,
        OP_ROTR  = 3'b010,
        OP_ROTL  = 3'b011,
        OP_CLEAR = 3'b100
    } op_e;

    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    state_e           state_q;
    op_e              op_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] rspData_q;
    logic             cmdReady_q;
    logic             rspValid_q;
    logic             rspErr_q;
    logic             abortHit;
    logic             rightOp;
    logic             legalOp;
    logic             unusedPower;

    // Power pins are carried through the netlist only.
    assign unusedPower = VDD ^ GND;

    assign rightOp = (op_q == OP_SHR) || (op_q == OP_ROTR) || (op_q == OP_CLEAR);
    assign legalOp = (cmd_op <= 3'b100);

`ifdef SHREG_CTRL_ABORT_EN
    logic rspAbort_q;
    assign abortHit  = (state_q == SHIFT) && abort;
    assign rsp_abort = rspAbort_q;
`else
    assign abortHit = 1'b0;
`endif

    assign cmd_ready = cmdReady_q;
    assign rsp_valid = rspValid_q;
    assign rsp_data  = rspData_q;
    assign rsp_err   = rspErr_q;

    // sel/din are decoded from state so rotate feedback sees the live head/tail word.
    always_comb begin
        sr_sel = 2'b00;
        sr_din = '0;
        if (state_q == SHIFT && !abortHit) begin
            case (op_q)
                OP_SHR:   begin sr_sel = 2'b01; sr_din = data_q; end
                OP_SHL:   begin sr_sel = 2'b10; sr_din = data_q; end
                OP_ROTR:  begin sr_sel = 2'b01; sr_din = tail_q; end
                OP_ROTL:  begin sr_sel = 2'b10; sr_din = head_q; end
                OP_CLEAR: begin sr_sel = 2'b01; sr_din = '0;     end
                default:  begin sr_sel = 2'b00; sr_din = '0;     end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            op_q       <= OP_SHR;
            count_q    <= '0;
            data_q     <= '0;
            rspData_q  <= '0;
            cmdReady_q <= 1'b0;
            rspValid_q <= 1'b0;
            rspErr_q   <= 1'b0;
`ifdef SHREG_CTRL_ABORT_EN
            rspAbort_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    cmdReady_q <= 1'b1;
                    if (cmd_valid && cmdReady_q) begin
                        cmdReady_q <= 1'b0;
                        rspData_q  <= '0;
                        if (legalOp) begin
                            op_q    <= op_e'(cmd_op);
                            data_q  <= cmd_data;
                            count_q <= (cmd_op == OP_CLEAR || cmd_count == '0) ? DEPTH_CNT : cmd_count;
                            state_q <= SHIFT;
                        end else begin
                            rspErr_q   <= 1'b1;
                            rspValid_q <= 1'b1;
                            state_q    <= RESP;
                        end
                    end
                end
                SHIFT: begin
                    if (abortHit) begin
                        rspValid_q <= 1'b1;
`ifdef SHREG_CTRL_ABORT_EN
                        rspAbort_q <= 1'b1;
`endif
                        state_q    <= RESP;
                    end else begin
                        // Word leaving the far end on this step becomes the response.
                        rspData_q <= rightOp ? tail_q : head_q;
                        count_q   <= count_q - 1'b1;
                        if (count_q == 1) begin
                            rspValid_q <= 1'b1;
                            state_q    <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rspValid_q <= 1'b0;
                        rspErr_q   <= 1'b0;
`ifdef SHREG_CTRL_ABORT_EN
                        rspAbort_q <= 1'b0;
`endif
                        cmdReady_q <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_reg_32b_ctrl.sv
// Self-checking bench for shift_reg_32b_ctrl: drives commands against a behavioural
// shift register and compares results with an index-arithmetic reference model.
module tb_shift_reg_32b_ctrl;

    localparam int WIDTH = 32;
    localparam int DEPTH = 1024;
    localparam int CW    = 11;

    logic             CLK = 1'b0;
    logic             RST;
    logic             VDD;
    logic             GND;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [CW-1:0]    cmd_count;
    logic [WIDTH-1:0] cmd_data;
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] tail_q;
    logic [1:0]       sr_sel;
    logic [WIDTH-1:0] sr_din;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_err;
`ifdef SHREG_CTRL_ABORT_EN
    logic             abort;
    logic             rsp_abort;
`endif

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] srArr   [DEPTH];
    logic [WIDTH-1:0] loadArr [DEPTH];
    logic [WIDTH-1:0] origArr [DEPTH];
    logic [WIDTH-1:0] expArr  [DEPTH];
    logic             loadReq;
    int               totalShifts = 0;
    int               badSel = 0;

    shift_reg_32b_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .VDD       (VDD),
        .GND       (GND),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_count (cmd_count),
        .cmd_data  (cmd_data),
        .head_q    (head_q),
        .tail_q    (tail_q),
        .sr_sel    (sr_sel),
        .sr_din    (sr_din),
`ifdef SHREG_CTRL_ABORT_EN
        .abort     (abort),
        .rsp_abort (rsp_abort),
`endif
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err)
    );

    always #5 CLK = ~CLK;

    assign head_q = srArr[0];
    assign tail_q = srArr[DEPTH-1];

    // Behavioural shift register array the controller drives.
    always @(posedge CLK) begin
        if (loadReq) begin
            srArr <= loadArr;
        end else if (sr_sel == 2'b01) begin
            srArr[0] <= sr_din;
            for (int i = 1; i < DEPTH; i++) srArr[i] <= srArr[i-1];
            totalShifts <= totalShifts + 1;
        end else if (sr_sel == 2'b10) begin
            srArr[DEPTH-1] <= sr_din;
            for (int i = 0; i < DEPTH-1; i++) srArr[i] <= srArr[i+1];
            totalShifts <= totalShifts + 1;
        end else if (sr_sel == 2'b11) begin
            badSel <= badSel + 1;
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic loadRegister(input bit randomFill, input logic [31:0] fillWord);
        for (int i = 0; i < DEPTH; i++) loadArr[i] = randomFill ? $urandom : fillWord;
        loadReq = 1'b1;
        tick();
        loadReq = 1'b0;
    endtask

    // Expected register image after n steps of op, computed from origArr by index arithmetic.
    task automatic buildExpected(input logic [2:0] op, input int n, input logic [31:0] data,
                                 output logic [31:0] lastOut);
        for (int i = 0; i < DEPTH; i++) begin
            case (op)
                3'd0:    expArr[i] = (i < n) ? data : origArr[(i - n + DEPTH) % DEPTH];
                3'd1:    expArr[i] = (i >= DEPTH - n) ? data : origArr[(i + n) % DEPTH];
                3'd2:    expArr[i] = origArr[(i - n + DEPTH) % DEPTH];
                3'd3:    expArr[i] = origArr[(i + n) % DEPTH];
                3'd4:    expArr[i] = (i < n) ? 32'h0 : origArr[(i - n + DEPTH) % DEPTH];
                default: expArr[i] = origArr[i];
            endcase
        end
        if (n == 0)                         lastOut = 32'h0;
        else if (op == 3'd1 || op == 3'd3)  lastOut = origArr[n-1];
        else                                lastOut = origArr[DEPTH-n];
    endtask

    function automatic int countMismatches();
        int m = 0;
        for (int i = 0; i < DEPTH; i++) if (srArr[i] !== expArr[i]) m++;
        return m;
    endfunction

    task automatic applyStimulus(input logic [2:0] op, input int cnt, input logic [31:0] data, input int rspDelay);
        int          n;
        int          waited;
        int          shiftsBefore;
        bit          legal;
        logic [31:0] expRsp;
        logic [31:0] expDin;
        legal  = (op <= 3'd4);
        n      = !legal ? 0 : ((op == 3'd4 || cnt == 0) ? DEPTH : cnt);
        origArr = srArr;
        buildExpected(legal ? op : 3'd7, n, data, expRsp);
        case (op)
            3'd0, 3'd1: expDin = data;
            3'd2:       expDin = origArr[DEPTH-1];
            3'd3:       expDin = origArr[0];
            default:    expDin = 32'h0;
        endcase
        checkOutput("idle cmd_ready", 32'(cmd_ready), 1);
        cmd_valid    = 1'b1;
        cmd_op       = op;
        cmd_count    = CW'(cnt);
        cmd_data     = data;
        shiftsBefore = totalShifts;
        tick();
        cmd_valid = 1'b0;
        cmd_op    = 3'($urandom);
        if (n > 0) begin
            checkOutput("step1 sel", 32'(sr_sel), (op == 3'd1 || op == 3'd3) ? 2 : 1);
            checkOutput("step1 din", sr_din, expDin);
            checkOutput("busy cmd_ready", 32'(cmd_ready), 0);
        end
        waited = 0;
        while (!rsp_valid && waited < n + 8) begin
            tick();
            waited++;
        end
        checkOutput("rsp latency", waited, n);
        checkOutput("shift count", totalShifts - shiftsBefore, n);
        checkOutput("rsp_err", 32'(rsp_err), legal ? 0 : 1);
        checkOutput("rsp_data", rsp_data, expRsp);
        checkOutput("resp sel", 32'(sr_sel), 0);
        checkOutput("register image", countMismatches(), 0);
        for (int d = 0; d < rspDelay; d++) begin
            tick();
            checkOutput("held rsp_valid", 32'(rsp_valid), 1);
            checkOutput("held rsp_data", rsp_data, expRsp);
            checkOutput("held rsp_err", 32'(rsp_err), legal ? 0 : 1);
            checkOutput("held cmd_ready", 32'(cmd_ready), 0);
            checkOutput("held sel", 32'(sr_sel), 0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checkOutput("post rsp_valid", 32'(rsp_valid), 0);
        checkOutput("post rsp_err", 32'(rsp_err), 0);
        checkOutput("post cmd_ready", 32'(cmd_ready), 1);
    endtask

    initial begin
        int          s0;
        logic [31:0] dummy;
        RST       = 1'b1;
        VDD       = 1'b1;
        GND       = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 3'b000;
        cmd_count = '0;
        cmd_data  = '0;
        rsp_ready = 1'b0;
        loadReq   = 1'b0;
`ifdef SHREG_CTRL_ABORT_EN
        abort     = 1'b0;
`endif

        $display("[TB] reset");
        for (int i = 0; i < DEPTH; i++) loadArr[i] = $urandom;
        loadReq = 1'b1;
        repeat (3) tick();
        loadReq = 1'b0;
        checkOutput("reset sel", 32'(sr_sel), 0);
        checkOutput("reset rsp_valid", 32'(rsp_valid), 0);
        checkOutput("reset cmd_ready", 32'(cmd_ready), 0);
        RST = 1'b0;
        tick();
        checkOutput("release cmd_ready", 32'(cmd_ready), 1);
        checkOutput("release rsp_data", rsp_data, 0);
        checkOutput("release rsp_err", 32'(rsp_err), 0);
        checkOutput("release din", sr_din, 0);
        s0 = totalShifts;
        repeat (3) tick();
        checkOutput("idle no shifts", totalShifts - s0, 0);

        $display("[TB] SHR count 4");
        loadRegister(1'b0, 32'h1111_2222);
        applyStimulus(3'd0, 4, 32'hA5A5_0001, 0);

        $display("[TB] ROTL full depth");
        loadRegister(1'b1, 32'h0);
        applyStimulus(3'd3, 0, $urandom, 1);

        $display("[TB] illegal op");
        applyStimulus(3'd7, 5, $urandom, 5);

        $display("[TB] CLEAR interrupted by reset");
        loadRegister(1'b1, 32'h0);
        origArr   = srArr;
        s0        = totalShifts;
        cmd_valid = 1'b1;
        cmd_op    = 3'd4;
        cmd_count = CW'($urandom);
        tick();
        cmd_valid = 1'b0;
        repeat (9) tick();
        RST = 1'b1;
        tick();
        checkOutput("rst sel", 32'(sr_sel), 0);
        checkOutput("rst rsp_valid", 32'(rsp_valid), 0);
        tick();
        RST = 1'b0;
        tick();
        checkOutput("rst cmd_ready", 32'(cmd_ready), 1);
        checkOutput("rst no response", 32'(rsp_valid), 0);
        checkOutput("rst shifts", totalShifts - s0, 10);
        buildExpected(3'd4, 10, 32'h0, dummy);
        checkOutput("rst partial image", countMismatches(), 0);
        applyStimulus(3'd1, 1, $urandom, 0);

`ifdef SHREG_CTRL_ABORT_EN
        $display("[TB] ROTR aborted after 20 steps");
        loadRegister(1'b1, 32'h0);
        origArr   = srArr;
        s0        = totalShifts;
        cmd_valid = 1'b1;
        cmd_op    = 3'd2;
        cmd_count = CW'(100);
        tick();
        cmd_valid = 1'b0;
        repeat (20) tick();
        abort = 1'b1;
        #1;
        checkOutput("abort sel", 32'(sr_sel), 0);
        tick();
        abort = 1'b0;
        buildExpected(3'd2, 20, 32'h0, dummy);
        checkOutput("abort rsp_valid", 32'(rsp_valid), 1);
        checkOutput("abort flag", 32'(rsp_abort), 1);
        checkOutput("abort rsp_data", rsp_data, dummy);
        checkOutput("abort shifts", totalShifts - s0, 20);
        checkOutput("abort image", countMismatches(), 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checkOutput("abort cleared", 32'(rsp_abort), 0);
        checkOutput("abort rsp dropped", 32'(rsp_valid), 0);
`endif

        $display("[TB] random commands");
        for (int k = 0; k < 10; k++) begin
            logic [2:0] rop;
            int         rcnt;
            rop  = 3'($urandom_range(0, 6));
            rcnt = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 40);
            applyStimulus(rop, rcnt, $urandom, $urandom_range(0, 3));
        end

        checkOutput("sel 11 never driven", badSel, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
